// File: rtl/bus_dma_master.sv
// Single-channel bus copy engine: reads LENGTH words from SRC and writes them to DST over the shared bus.
// Latency: 3 cycles per word under continuous grant, plus one REQ and one FIN cycle; stalls in RD/WR without grant.
module bus_dma_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              M_req,
    input  logic              M_grant,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_dout,
    input  logic [DATA_W-1:0] M_din
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_word;

    assign last_word = (cnt_q == (len_q - ADDR_W'(1)));

    // The bus address is registered and loaded on the transition into RD/WR,
    // so it is already valid during the first cycle of each bus phase.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (M_grant) begin
                    addr_d  = src_q + cnt_q;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (M_grant) begin
                    state_d = S_RDW;
                end
            end
            S_RDW: begin
                data_d  = M_din;
                addr_d  = dst_q + cnt_q;
                state_d = S_WR;
            end
            S_WR: begin
                if (M_grant) begin
                    if (last_word) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        addr_d  = src_q + cnt_q + ADDR_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign M_req     = (state_q == S_REQ) || (state_q == S_RD) ||
                       (state_q == S_RDW) || (state_q == S_WR);
    assign M_wr      = (state_q == S_WR);
    assign M_address = addr_q;
    assign M_dout    = data_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: two instances on a modelled shared bus with registered read return and a hold arbiter.
// Expected writes are queued at start and matched against committed bus writes.
module tb_bus_dma_master;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start0, start1;
    logic [AW-1:0] src0, dst0, len0, src1, dst1, len1;
    logic          busy0, done0, req0, wr0, busy1, done1, req1, wr1;
    logic          g0, g1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] dout0, dout1, rd_q;
    logic          force_gnt, arb_mode;
    logic [1:0]    owner;
    logic [DW-1:0] mem [0:255];
    wr_t           sb0[$];
    wr_t           sb1[$];
    wr_t           e0, e1;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    bus_dma_master #(.ADDR_W(AW), .DATA_W(DW)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .src_addr(src0), .dst_addr(dst0), .len(len0),
        .busy(busy0), .done(done0), .M_req(req0), .M_grant(g0), .M_wr(wr0),
        .M_address(addr0), .M_dout(dout0), .M_din(rd_q)
    );

    bus_dma_master #(.ADDR_W(AW), .DATA_W(DW)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .src_addr(src1), .dst_addr(dst1), .len(len1),
        .busy(busy1), .done(done1), .M_req(req1), .M_grant(g1), .M_wr(wr1),
        .M_address(addr1), .M_dout(dout1), .M_din(rd_q)
    );

    assign g0 = arb_mode ? (owner == 2'd1) : force_gnt;
    assign g1 = arb_mode && (owner == 2'd2);

    // Bus model: registered read mux, write commit at the edge under grant, hold arbiter.
    always @(posedge clk) begin
        if (g0 && wr0) mem[addr0] = dout0;
        else if (g1 && wr1) mem[addr1] = dout1;
        if (g0 && !wr0) rd_q <= mem[addr0];
        else if (g1 && !wr1) rd_q <= mem[addr1];
        if (!arb_mode) owner <= 2'd0;
        else if (owner == 2'd0) owner <= req0 ? 2'd1 : (req1 ? 2'd2 : 2'd0);
        else if (owner == 2'd1 && !req0) owner <= req1 ? 2'd2 : 2'd0;
        else if (owner == 2'd2 && !req1) owner <= req0 ? 2'd1 : 2'd0;
    end

    always @(negedge clk) begin
        if (reset_n && wr0 && g0) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL m0_write unexpected addr=%h data=%h", addr0, dout0);
            end else begin
                e0 = sb0.pop_front();
                if (addr0 !== e0.a || dout0 !== e0.d) begin
                    failures++;
                    $display("FAIL m0_write got addr=%h data=%h want addr=%h data=%h", addr0, dout0, e0.a, e0.d);
                end
            end
        end
        if (reset_n && wr1 && g1) begin
            checks++;
            if (sb1.size() == 0) begin
                failures++;
                $display("FAIL m1_write unexpected addr=%h data=%h", addr1, dout1);
            end else begin
                e1 = sb1.pop_front();
                if (addr1 !== e1.a || dout1 !== e1.d) begin
                    failures++;
                    $display("FAIL m1_write got addr=%h data=%h want addr=%h data=%h", addr1, dout1, e1.a, e1.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int m, input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        wr_t it;
        for (int i = 0; i < int'(l); i++) begin
            it.a = d + AW'(i);
            it.d = mem[s + AW'(i)];
            if (m == 0) sb0.push_back(it);
            else sb1.push_back(it);
        end
    endtask

    // Returns at #1 after the edge that sampled start (the first busy cycle).
    task automatic start_m0(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        push_exp(0, s, d, l);
        src0 = s; dst0 = d; len0 = l; start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        tick();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done got=0 want=1 within %0d cycles", name, bound);
        end
    endtask

    task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [DW-1:0] want);
        checks++;
        if (mem[a] !== want) begin
            failures++;
            $display("FAIL %s mem[%h] got=%h want=%h", name, a, mem[a], want);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            failures++;
            $display("FAIL %s pending writes got=%0d/%0d want=0/0", name, sb0.size(), sb1.size());
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start0 = 0; start1 = 0; force_gnt = 1'b1; arb_mode = 1'b0;
        src0 = '0; dst0 = '0; len0 = '0; src1 = '0; dst1 = '0; len1 = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy0, done0, req0, wr0} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {busy0, done0, req0, wr0});
        end
        checks++;
        if (addr0 !== '0 || dout0 !== '0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h dout=%h want 0/0", addr0, dout0);
        end
        checks++;
        if ({busy1, done1, req1, wr1} !== 4'b0 || addr1 !== '0 || dout1 !== '0) begin
            failures++;
            $display("FAIL reset_m1 got ctrl=%b addr=%h dout=%h want 0", {busy1, done1, req1, wr1}, addr1, dout1);
        end
        tick();
    endtask

    task automatic test_copy;
        int busy_n, done_n, done_at;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        busy_n = 0; done_n = 0; done_at = -1;
        start_m0(8'h00, 8'h80, 8'd4);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy0) busy_n++;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        tick();
        checks++;
        if (busy_n != 14) begin failures++; $display("FAIL copy_busy_cycles got=%0d want=14", busy_n); end
        checks++;
        if (done_n != 1) begin failures++; $display("FAIL copy_done_pulses got=%0d want=1", done_n); end
        checks++;
        if (done_at != 13) begin failures++; $display("FAIL copy_done_latency got=%0d want=13", done_at); end
        for (int i = 0; i < 4; i++) check_mem("copy", 8'h80 + AW'(i), 32'hA0 + i);
        check_sb_empty("copy");
    endtask

    task automatic test_len0;
        int busy_n, done_n, done_at, req_n, wr_n;
        busy_n = 0; done_n = 0; done_at = -1; req_n = 0; wr_n = 0;
        start_m0(8'h10, 8'h90, 8'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy0) busy_n++;
            if (req0) req_n++;
            if (wr0) wr_n++;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        tick();
        checks++;
        if (req_n != 0 || wr_n != 0) begin failures++; $display("FAIL len0_bus got req=%0d wr=%0d want 0/0", req_n, wr_n); end
        checks++;
        if (done_n != 1 || done_at != 0) begin failures++; $display("FAIL len0_done got n=%0d at=%0d want 1 at 0", done_n, done_at); end
        checks++;
        if (busy_n != 1) begin failures++; $display("FAIL len0_busy got=%0d want=1", busy_n); end
    endtask

    task automatic test_stall;
        int bad;
        bad = 0;
        for (int i = 0; i < 3; i++) mem[8'h20 + i] = 32'hC0 + i;
        start_m0(8'h20, 8'h90, 8'd3);
        repeat (6) tick();
        force_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wr0 !== 1'b1 || addr0 !== 8'h91 || dout0 !== 32'hC1) bad++;
        end
        @(posedge clk);
        #1 force_gnt = 1'b1;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable cycles want=0", bad); end
        checks++;
        if (mem[8'h91] !== 32'h0) begin failures++; $display("FAIL stall_no_early_write got=%h want=0", mem[8'h91]); end
        wait_done0(100, "stall");
        for (int i = 0; i < 3; i++) check_mem("stall", 8'h90 + AW'(i), 32'hC0 + i);
        check_sb_empty("stall");
    endtask

    task automatic test_wrap;
        mem[8'hFE] = 32'hD0; mem[8'hFF] = 32'hD1; mem[8'h00] = 32'hD2;
        start_m0(8'hFE, 8'h02, 8'd3);
        wait_done0(100, "wrap");
        check_mem("wrap", 8'h02, 32'hD0);
        check_mem("wrap", 8'h03, 32'hD1);
        check_mem("wrap", 8'h04, 32'hD2);
        check_sb_empty("wrap");
    endtask

    task automatic test_arb;
        int bad;
        logic s0, s1;
        bad = 0; s0 = 0; s1 = 0;
        for (int i = 0; i < 3; i++) mem[8'h40 + i] = 32'hE0 + i;
        for (int i = 0; i < 2; i++) mem[8'h50 + i] = 32'hF0 + i;
        arb_mode = 1'b1;
        push_exp(0, 8'h50, 8'hD0, 8'd2);
        push_exp(1, 8'h40, 8'hC0, 8'd3);
        src0 = 8'h50; dst0 = 8'hD0; len0 = 8'd2;
        src1 = 8'h40; dst1 = 8'hC0; len1 = 8'd3;
        start0 = 1'b1; start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        for (int c = 0; c < 100 && !(s0 && s1); c++) begin
            @(negedge clk);
            if (g0 && g1) bad++;
            if ((wr0 && g1) || (wr1 && g0)) bad++;
            if (done0) s0 = 1'b1;
            if (done1) s1 = 1'b1;
        end
        tick();
        arb_mode = 1'b0;
        checks++;
        if (!(s0 && s1)) begin failures++; $display("FAIL arb_done got=%b%b want=11", s0, s1); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL arb_exclusive got=%0d violations want=0", bad); end
        for (int i = 0; i < 2; i++) check_mem("arb_m0", 8'hD0 + AW'(i), 32'hF0 + i);
        for (int i = 0; i < 3; i++) check_mem("arb_m1", 8'hC0 + AW'(i), 32'hE0 + i);
        check_sb_empty("arb");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin
            mem[8'h60 + i] = 32'hB0 + i;
            mem[8'hA0 + i] = '0;
        end
        start_m0(8'h60, 8'hA0, 8'd4);
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, req0, wr0} !== 4'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl got=%b want=0000", {busy0, done0, req0, wr0});
        end
        checks++;
        if (addr0 !== '0 || dout0 !== '0) begin
            failures++;
            $display("FAIL rst_mid_bus got addr=%h dout=%h want 0/0", addr0, dout0);
        end
        checks++;
        if (sb0.size() != 3) begin failures++; $display("FAIL rst_mid_progress got=%0d pending want=3", sb0.size()); end
        sb0.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (4) tick();
        check_mem("rst_mid_no_write", 8'hA1, 32'h0);
        start_m0(8'h63, 8'hB0, 8'd1);
        wait_done0(50, "rst_restart");
        check_mem("rst_restart", 8'hB0, 32'hB3);
        check_sb_empty("rst_restart");
    endtask

    initial begin
        test_reset();
        test_copy();
        test_len0();
        test_stall();
        test_wrap();
        test_arb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
